instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the byte address of the first instruction fetched after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port imem_req, output, 1, instruction memory read request.
REQ-005 SHALL have port imem_addr, output, 16, byte address of the requested instruction.
REQ-006 SHALL have port imem_ack, input, 1, memory read complete; imem_rdata is valid in the same cycle.
REQ-007 SHALL have port imem_rdata, input, 16, instruction word returned by memory.
REQ-008 SHALL have port instr, output, 16, the held instruction word.
REQ-009 SHALL have port opcode, output, 3, equal to instr[15:13] and feeding the control unit.
REQ-010 SHALL have port pc, output, 16, address of the held instruction.
REQ-011 SHALL have port instr_valid, output, 1, meaning instr, opcode and pc are valid.
REQ-012 SHALL have port instr_ready, input, 1, meaning downstream retires the held instruction this cycle.
REQ-013 SHALL have port pc_src, input, 2, next-PC select: 2'b10 selects jump; all other values select sequential or branch.
REQ-014 SHALL have port branch_taken, input, 1, meaning the branch condition is met; sampled only when retiring.
REQ-015 SHALL have port branch_target, input, 16, byte address of the branch destination.

Function
REQ-016 SHALL implement a two-state FSM: FETCH and ISSUE.
REQ-017 In FETCH, SHALL drive imem_req=1 and imem_addr=pc, holding both stable until imem_ack.
REQ-018 On imem_ack in FETCH, SHALL register imem_rdata into instr and move to ISSUE; instr_valid=1 from the next cycle.
REQ-019 In ISSUE, SHALL hold instr_valid=1 and keep instr and pc stable until instr_ready=1.
REQ-020 On instr_ready in ISSUE, SHALL load the next PC, return to FETCH and drop instr_valid in the next cycle.
REQ-021 Next PC priority SHALL be: (1) pc_src=2'b10 gives {pc_plus2[15:14], instr[12:0], 1'b0}; (2) branch_taken=1 gives {branch_target[15:1], 1'b0}; (3) otherwise pc_plus2.
REQ-022 pc_plus2 SHALL equal pc+2 modulo 2^16, so 16'hFFFE wraps to 16'h0000.
REQ-023 pc_src values 2'b00, 2'b01 and 2'b11 SHALL behave identically and SHALL NOT be flagged as errors.
REQ-024 imem_ack while imem_req=0 SHALL be ignored.
REQ-025 instr_ready while instr_valid=0 SHALL be ignored.
REQ-026 Minimum throughput SHALL be one instruction per 2 cycles, with zero-wait memory and instr_ready held high.

Reset
REQ-027 rst=1 SHALL immediately and asynchronously force: state FETCH, pc=RESET_PC, instr=16'h0000, instr_valid=0, imem_req=0.
REQ-028 A fetch in flight at reset SHALL be abandoned; an imem_ack arriving during reset SHALL be discarded.
REQ-029 imem_req SHALL assert in the first clk cycle after rst deasserts, with imem_addr=RESET_PC.

Configuration
REQ-030 With the macro INSTR_FETCH_STATS_EN defined, SHALL add two ports:
- fetch_count, output, 16: increments on each retired instruction (instr_valid and instr_ready).
- stall_count, output, 16: increments on each cycle with (imem_req and not imem_ack) or (instr_valid and not instr_ready).
- Both counters saturate at 16'hFFFF and reset to 0.
REQ-031 Without INSTR_FETCH_STATS_EN, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Shared package isa_pkg SHALL hold:
- opcode constants: ADD=000, ADDI=001, SHIFT=010, ROTATE=011, BEQ=100, SW=101, LW=110, JMP=111;
- PCSRC_JUMP=2'b10;
- PC_STEP=2;
- the fetch FSM state enum.
REQ-033 Next-PC selection SHALL be a combinational sub-module, fetch_next_pc (inputs: pc, instr, pc_src, branch_taken, branch_target; output: next_pc).

Verification
REQ-034 Release rst with RESET_PC=16'h0100, zero-wait ack, instr_ready=1 -> imem_addr sequence 0100, 0102, 0104; instr_valid on alternate cycles.
REQ-035 Hold instr 16'hE00A (JMP) at pc=16'h0040 with pc_src=2'b10 and instr_ready -> next imem_addr=16'h0014.
REQ-036 Hold instr 16'h8000 (BEQ) with branch_taken=1 and branch_target=16'h0203 -> next imem_addr=16'h0202; repeat with branch_taken=0 -> pc+2.
REQ-037 pc=16'hFFFE, sequential retire -> next imem_addr=16'h0000.
REQ-038 Apply 3 wait cycles before imem_ack, then hold instr_ready=0 for 4 cycles ->
- imem_addr stable during the wait, instr stable during the hold;
- with INSTR_FETCH_STATS_EN, stall_count=7 and fetch_count=1 after retire.
REQ-039 Assert rst while waiting for imem_ack -> imem_req=0 asynchronously; after release, imem_addr=RESET_PC and the stale ack is not captured.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode encodings, next-PC select codes, PC step
// and the fetch FSM state type.
package isa_pkg;

   localparam logic [2:0] OP_ADD    = 3'b000;
   localparam logic [2:0] OP_ADDI   = 3'b001;
   localparam logic [2:0] OP_SHIFT  = 3'b010;
   localparam logic [2:0] OP_ROTATE = 3'b011;
   localparam logic [2:0] OP_BEQ    = 3'b100;
   localparam logic [2:0] OP_SW     = 3'b101;
   localparam logic [2:0] OP_LW     = 3'b110;
   localparam logic [2:0] OP_JMP    = 3'b111;

   localparam logic [1:0]  PCSRC_JUMP = 2'b10;
   localparam logic [15:0] PC_STEP    = 16'd2;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: jump beats branch, branch beats sequential.
module fetch_next_pc
   import isa_pkg::*;
(
   input  logic [15:0] pc,
   input  logic [15:0] instr,
   input  logic [1:0]  pc_src,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic [15:0] next_pc
);

   logic [15:0] pc_plus2_s;
   logic        unused_bits_s;

   assign pc_plus2_s    = pc + PC_STEP;
   assign unused_bits_s = ^{instr[15:13], branch_target[0]};

   // Prioritised next-PC mux; targets are forced to halfword alignment.
   always_comb begin
      next_pc = pc_plus2_s;
      if (pc_src == PCSRC_JUMP) begin
         next_pc = {pc_plus2_s[15:14], instr[12:0], 1'b0};
      end else if (branch_taken) begin
         next_pc = {branch_target[15:1], 1'b0};
      end else begin
         next_pc = pc_plus2_s;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Two-state instruction fetch unit holding one instruction for downstream.
// Optional statistics counters are enabled with the INSTR_FETCH_STATS_EN macro.
module instr_fetch
   import isa_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic [2:0]  opcode,
   output logic [15:0] pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic [1:0]  pc_src,
   input  logic        branch_taken,
   input  logic [15:0] branch_target
`ifdef INSTR_FETCH_STATS_EN
   ,
   output logic [15:0] fetch_count,
   output logic [15:0] stall_count
`endif
);

   fetch_state_e state_r;
   logic [15:0]  pc_r;
   logic [15:0]  instr_r;
   logic         instr_valid_r;
   logic         imem_req_r;
   logic [15:0]  next_pc_s;

   fetch_next_pc u_next_pc (
      .pc            (pc_r),
      .instr         (instr_r),
      .pc_src        (pc_src),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .next_pc       (next_pc_s)
   );

   // Fetch/issue FSM. After reset the request rises one edge later, so an ack
   // that was pending across reset is seen with imem_req low and dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= FETCH;
         pc_r          <= RESET_PC;
         instr_r       <= 16'h0000;
         instr_valid_r <= 1'b0;
         imem_req_r    <= 1'b0;
      end else begin
         case (state_r)
            FETCH: begin
               if (!imem_req_r) begin
                  imem_req_r <= 1'b1;
               end else if (imem_ack) begin
                  instr_r       <= imem_rdata;
                  imem_req_r    <= 1'b0;
                  instr_valid_r <= 1'b1;
                  state_r       <= ISSUE;
               end
            end
            ISSUE: begin
               if (instr_ready) begin
                  pc_r          <= next_pc_s;
                  instr_valid_r <= 1'b0;
                  imem_req_r    <= 1'b1;
                  state_r       <= FETCH;
               end
            end
            default: begin
               state_r       <= FETCH;
               instr_valid_r <= 1'b0;
               imem_req_r    <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = imem_req_r;
   assign imem_addr   = pc_r;
   assign instr       = instr_r;
   assign opcode      = instr_r[15:13];
   assign pc          = pc_r;
   assign instr_valid = instr_valid_r;

`ifdef INSTR_FETCH_STATS_EN
   logic [15:0] fetch_count_r;
   logic [15:0] stall_count_r;
   logic        retire_s;
   logic        stall_s;

   assign retire_s = instr_valid_r && instr_ready;
   assign stall_s  = (imem_req_r && !imem_ack) || (instr_valid_r && !instr_ready);

   // Saturating retire and stall counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count_r <= 16'h0000;
         stall_count_r <= 16'h0000;
      end else begin
         if (retire_s && (fetch_count_r != 16'hFFFF)) begin
            fetch_count_r <= fetch_count_r + 16'd1;
         end
         if (stall_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
         end
      end
   end

   assign fetch_count = fetch_count_r;
   assign stall_count = stall_count_r;
`endif

endmodule
